// File: rtl/decode_stage.sv
// Single-issue decode stage: splits a packed instruction into a registered control/address bundle,
// with valid/ready handshake, a one-slot load-use interlock, a halt state and a saturating retire counter.
module decode_stage #(
  parameter  int NUM_REGS    = 12,
  parameter  int INSTR_WIDTH = 9,
  parameter  int RT_BASE     = 4,
  parameter  int RD_BASE     = 8,
  parameter  int ACC_REG     = 11,
  localparam int AW          = $clog2(NUM_REGS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INSTR_WIDTH-1:0] instruction,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2:0]             alu_op,
  output logic [AW-1:0]          rs_addr,
  output logic [AW-1:0]          rt_addr,
  output logic [AW-1:0]          rd_addr,
  output logic [2:0]             imm,
  output logic                   sel_imm,
  output logic                   reg_write,
  output logic                   branch,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic                   mem2reg,
  output logic                   halt,
  output logic                   illegal,
  output logic [15:0]            retired_count
);

  localparam int SW = AW + 2;
  localparam logic [SW-1:0] NR  = SW'(NUM_REGS);
  localparam logic [SW-1:0] RTB = SW'(RT_BASE);
  localparam logic [SW-1:0] RDB = SW'(RD_BASE);
  localparam logic [SW-1:0] ACC = SW'(ACC_REG);

  typedef enum logic {RUN, HALTED} state_e;
  state_e state_q, state_d;

  logic [2:0] op, t1, t2;
  logic [1:0] fa, fb, fc;
  assign op = instruction[INSTR_WIDTH-1 -: 3];
  assign fa = instruction[5:4];
  assign fb = instruction[3:2];
  assign fc = instruction[1:0];
  assign t1 = instruction[5:3];
  assign t2 = instruction[2:0];

  logic [2:0]    d_alu, d_imm;
  logic [SW-1:0] d_rs, d_rt, d_rd;
  logic          d_sel, d_rw, d_br, d_mr, d_mw, d_m2r, d_halt, d_ill, d_lw;
  logic          use_rs, use_rt, use_rd, bad_op, bad_addr;

  always_comb begin
    d_alu = '0; d_imm = '0; d_rs = '0; d_rt = '0; d_rd = '0;
    d_sel = 1'b0; d_rw = 1'b0; d_br = 1'b0; d_mr = 1'b0; d_mw = 1'b0;
    d_m2r = 1'b0; d_halt = 1'b0; d_ill = 1'b0; d_lw = 1'b0;
    use_rs = 1'b0; use_rt = 1'b0; use_rd = 1'b0; bad_op = 1'b0;
    unique case (op)
      3'b000: begin
        d_rs = SW'(fa); use_rs = 1'b1;
        if (fc == 2'b11) begin
          d_alu = 3'd6; d_br = 1'b1;
        end else begin
          d_alu = {1'b0, fc};
          d_rt = SW'(fb) + RTB; use_rt = 1'b1;
          d_rd = ACC; use_rd = 1'b1; d_rw = 1'b1;
        end
      end
      3'b001: begin
        unique case (fc)
          2'b00: begin
            d_alu = 3'd6; d_rs = SW'(fb) + RTB; use_rs = 1'b1;
            d_rd = SW'(fa); use_rd = 1'b1;
            d_mr = 1'b1; d_m2r = 1'b1; d_rw = 1'b1; d_lw = 1'b1;
          end
          2'b01: begin
            d_alu = 3'd6; d_rs = SW'(fa); use_rs = 1'b1;
            d_rt = SW'(fb) + RTB; use_rt = 1'b1; d_mw = 1'b1;
          end
          default: bad_op = 1'b1;
        endcase
      end
      3'b010: begin
        d_alu = 3'd3; d_rs = SW'(fa); use_rs = 1'b1;
        d_rt = SW'(fb) + RTB; use_rt = 1'b1;
        d_rd = SW'(fc) + RDB; use_rd = 1'b1; d_rw = 1'b1;
      end
      3'b011: begin
        d_alu = 3'd3; d_rs = SW'(fa); use_rs = 1'b1;
        d_rd = SW'(fb) + RDB; use_rd = 1'b1;
        d_imm = {1'b0, fc}; d_sel = 1'b1; d_rw = 1'b1;
      end
      3'b100: begin
        d_alu = 3'd6; d_rs = SW'(t2) + RTB; use_rs = 1'b1;
        d_rd = SW'(t1); use_rd = 1'b1; d_rw = 1'b1;
      end
      3'b101: begin
        d_alu = 3'd6; d_rs = SW'(t1); use_rs = 1'b1;
        d_rd = SW'(t2) + RTB; use_rd = 1'b1; d_rw = 1'b1;
      end
      3'b110: bad_op = 1'b1;
      default: d_halt = 1'b1;
    endcase
    bad_addr = (use_rs && d_rs >= NR) || (use_rt && d_rt >= NR) || (use_rd && d_rd >= NR);
    // Illegal encodings collapse to an all-zero bundle that reads no registers
    if (bad_op || bad_addr) begin
      d_alu = '0; d_imm = '0; d_rs = '0; d_rt = '0; d_rd = '0;
      d_sel = 1'b0; d_rw = 1'b0; d_br = 1'b0; d_mr = 1'b0; d_mw = 1'b0;
      d_m2r = 1'b0; d_halt = 1'b0; d_lw = 1'b0; d_ill = 1'b1;
      use_rs = 1'b0; use_rt = 1'b0; use_rd = 1'b0;
    end
  end

  logic          out_valid_q, out_valid_d, lw_v_q, lw_v_d, lu_stall, accept, xfer;
  logic [AW-1:0] lw_rd_q;
  logic [15:0]   cnt_q, cnt_d;

  assign lu_stall = lw_v_q && in_valid &&
                    ((use_rs && d_rs[AW-1:0] == lw_rd_q) || (use_rt && d_rt[AW-1:0] == lw_rd_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush)                                      state_d = RUN;
    else if (state_q == RUN && accept && d_halt)    state_d = HALTED;
  end

  always_comb begin
    in_ready = (state_q == RUN) && !lu_stall && (!out_valid_q || out_ready);
    accept   = in_valid && in_ready && !flush;
  end

  assign xfer        = out_valid_q && out_ready && !illegal && !flush;
  assign cnt_d       = (xfer && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
  assign lw_v_d      = accept && d_lw;
  assign out_valid_d = flush ? 1'b0 : accept ? 1'b1 : out_ready ? 1'b0 : out_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0; lw_v_q <= 1'b0; lw_rd_q <= '0; cnt_q <= '0;
      alu_op <= '0; rs_addr <= '0; rt_addr <= '0; rd_addr <= '0; imm <= '0;
      sel_imm <= 1'b0; reg_write <= 1'b0; branch <= 1'b0; mem_read <= 1'b0;
      mem_write <= 1'b0; mem2reg <= 1'b0; halt <= 1'b0; illegal <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      lw_v_q      <= lw_v_d;
      cnt_q       <= cnt_d;
      if (lw_v_d) lw_rd_q <= d_rd[AW-1:0];
      if (accept) begin
        alu_op <= d_alu; rs_addr <= d_rs[AW-1:0]; rt_addr <= d_rt[AW-1:0];
        rd_addr <= d_rd[AW-1:0]; imm <= d_imm; sel_imm <= d_sel; reg_write <= d_rw;
        branch <= d_br; mem_read <= d_mr; mem_write <= d_mw; mem2reg <= d_m2r;
        halt <= d_halt; illegal <= d_ill;
      end
    end
  end

  assign out_valid     = out_valid_q;
  assign retired_count = cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: default instance for the main flow, NUM_REGS=8 instance for range-illegal decode.
module tb_decode_stage;

  logic clk, rst_n;
  logic in_valid, in_ready, flush, out_valid, out_ready;
  logic [8:0]  instr;
  logic [2:0]  alu_op, imm;
  logic [3:0]  rs_addr, rt_addr, rd_addr;
  logic        sel_imm, reg_write, branch, mem_read, mem_write, mem2reg, halt, illegal;
  logic [15:0] retired;

  logic in_valid8, in_ready8, flush8, out_valid8, out_ready8;
  logic [8:0]  instr8;
  logic [2:0]  alu_op8, imm8;
  logic [2:0]  rs8, rt8, rd8;
  logic        sel8, rw8, br8, mr8, mw8, m2r8, halt8, ill8;
  logic [15:0] retired8;

  int n_pass = 0;
  int n_total = 0;

  decode_stage u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instr), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .alu_op(alu_op), .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr), .imm(imm),
    .sel_imm(sel_imm), .reg_write(reg_write), .branch(branch), .mem_read(mem_read),
    .mem_write(mem_write), .mem2reg(mem2reg), .halt(halt), .illegal(illegal),
    .retired_count(retired)
  );

  decode_stage #(.NUM_REGS(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .instruction(instr8), .flush(flush8), .out_valid(out_valid8), .out_ready(out_ready8),
    .alu_op(alu_op8), .rs_addr(rs8), .rt_addr(rt8), .rd_addr(rd8), .imm(imm8),
    .sel_imm(sel8), .reg_write(rw8), .branch(br8), .mem_read(mr8),
    .mem_write(mw8), .mem2reg(m2r8), .halt(halt8), .illegal(ill8),
    .retired_count(retired8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; instr = '0; flush = 1'b0; out_ready = 1'b1;
    in_valid8 = 1'b0; instr8 = '0; flush8 = 1'b0; out_ready8 = 1'b1;
    #3;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_retired", retired, 16'd0);
    check("rst_alu_op", alu_op, 3'd0);
    step(); step();
    rst_n = 1'b1;
    check("post_rst_in_ready", in_ready, 1'b1);

    // ADD -> ADDI -> SLT back to back
    in_valid = 1'b1; instr = 9'b010_01_10_11;
    step();
    check("add_valid", out_valid, 1'b1);
    check("add_rs", rs_addr, 4'd1);
    check("add_rt", rt_addr, 4'd6);
    check("add_rd", rd_addr, 4'd11);
    check("add_alu", alu_op, 3'd3);
    check("add_rw", reg_write, 1'b1);
    check("add_sel", sel_imm, 1'b0);
    instr = 9'b011_11_01_10;
    step();
    check("addi_rs", rs_addr, 4'd3);
    check("addi_rd", rd_addr, 4'd9);
    check("addi_imm", imm, 3'd2);
    check("addi_sel", sel_imm, 1'b1);
    check("addi_rt", rt_addr, 4'd0);
    check("retired_1", retired, 16'd1);
    instr = 9'b000_10_11_01;
    step();
    check("slt_alu", alu_op, 3'd1);
    check("slt_rs", rs_addr, 4'd2);
    check("slt_rt", rt_addr, 4'd7);
    check("slt_rd", rd_addr, 4'd11);
    check("retired_2", retired, 16'd2);

    // Load-use: LW r2 then ADD reading r2
    instr = 9'b001_10_01_00;
    step();
    check("lw_rs", rs_addr, 4'd5);
    check("lw_rd", rd_addr, 4'd2);
    check("lw_m2r", mem2reg, 1'b1);
    check("lw_mr", mem_read, 1'b1);
    check("lw_alu", alu_op, 3'd6);
    check("retired_3", retired, 16'd3);
    instr = 9'b010_10_00_00;
    #1;
    check("lu_stall_ready", in_ready, 1'b0);
    step();
    check("lu_bubble_valid", out_valid, 1'b0);
    check("lu_release_ready", in_ready, 1'b1);
    check("retired_4", retired, 16'd4);
    step();
    check("dep_add_valid", out_valid, 1'b1);
    check("dep_add_rs", rs_addr, 4'd2);
    check("dep_add_rt", rt_addr, 4'd4);
    check("dep_add_rd", rd_addr, 4'd8);
    instr = 9'b001_01_11_01;
    step();
    check("sw_rs", rs_addr, 4'd1);
    check("sw_rt", rt_addr, 4'd7);
    check("sw_mw", mem_write, 1'b1);
    check("sw_rw", reg_write, 1'b0);
    instr = 9'b101_010_011;
    step();
    check("tr2_rs", rs_addr, 4'd2);
    check("tr2_rd", rd_addr, 4'd7);
    check("tr2_rw", reg_write, 1'b1);
    in_valid = 1'b0;
    step();
    check("drain_valid", out_valid, 1'b0);
    check("retired_7", retired, 16'd7);

    // Backpressure holds the TR1 bundle
    out_ready = 1'b0; in_valid = 1'b1; instr = 9'b100_011_001;
    step();
    check("tr1_rs", rs_addr, 4'd5);
    check("tr1_rd", rd_addr, 4'd3);
    instr = 9'b010_01_10_11;
    for (int unsigned i = 0; i < 5; i++) begin
      step();
      check("bp_ready", in_ready, 1'b0);
      check("bp_valid", out_valid, 1'b1);
      check("bp_rs", rs_addr, 4'd5);
      check("bp_rd", rd_addr, 4'd3);
      check("bp_retired", retired, 16'd7);
    end
    out_ready = 1'b1; in_valid = 1'b0;
    step();
    check("bp_release_valid", out_valid, 1'b0);
    check("retired_8", retired, 16'd8);

    // Illegal opcodes
    in_valid = 1'b1; instr = 9'b110_000000;
    step();
    check("ill_op_flag", illegal, 1'b1);
    check("ill_op_rw", reg_write, 1'b0);
    check("ill_op_valid", out_valid, 1'b1);
    instr = 9'b001_00_00_10;
    step();
    check("ill_c_flag", illegal, 1'b1);
    check("ill_c_mr", mem_read, 1'b0);
    in_valid = 1'b0;
    step();
    check("ill_retired", retired, 16'd8);

    // HALT then flush recovery
    in_valid = 1'b1; instr = 9'b111_000000;
    step();
    check("halt_flag", halt, 1'b1);
    check("halt_rw", reg_write, 1'b0);
    check("halt_ready", in_ready, 1'b0);
    instr = 9'b010_01_10_11;
    for (int unsigned i = 0; i < 4; i++) begin
      step();
      check("halted_ready", in_ready, 1'b0);
      check("halted_valid", out_valid, 1'b0);
    end
    check("retired_9", retired, 16'd9);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_ready", in_ready, 1'b1);
    check("flush_valid", out_valid, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_no_accept", out_valid, 1'b0);
    check("flush_retired", retired, 16'd9);
    step();
    check("post_flush_accept", out_valid, 1'b1);
    check("post_flush_rd", rd_addr, 4'd11);

    // NUM_REGS=8: TR1 with t2=7 gives rs=11, out of range
    in_valid = 1'b0;
    in_valid8 = 1'b1; instr8 = 9'b100_000_111;
    step();
    check("n8_ill_flag", ill8, 1'b1);
    check("n8_ill_rw", rw8, 1'b0);
    instr8 = 9'b100_000_011;
    step();
    check("n8_ok_flag", ill8, 1'b0);
    check("n8_ok_rs", rs8, 3'd7);
    check("n8_ok_rw", rw8, 1'b1);
    in_valid8 = 1'b0;

    // Asynchronous reset mid-stream
    in_valid = 1'b1; instr = 9'b010_01_10_11;
    step();
    check("pre_rst_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    #2;
    check("async_rst_valid", out_valid, 1'b0);
    check("async_rst_retired", retired, 16'd0);
    check("async_rst_rd", rd_addr, 4'd0);
    in_valid = 1'b0;
    step();
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
